inst_mem_pipe: RTL and testbench

Parametrised instruction memory with a valid/ready fetch port, a 2-entry response buffer and a program-load write port. Successor to the fixed 1K×32 synchronous instruction ROM: it accepts one byte-addressed fetch per cycle, returns data with one-cycle latency, and holds responses under backpressure without loss. Sits between the RISC-V fetch stage and the boot loader/test harness that fills program memory.

---
 rtl/inst_mem_pkg.sv | 19 +
 rtl/inst_mem_fifo2.sv | 58 +++++
 rtl/inst_mem_pipe.sv | 116 +++++++++++
 tb/tb_inst_mem_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory slice.
//   NOP        : canonical RISC-V no-op (addi x0, x0, 0), substituted for
//                misaligned fetches when alignment checking is compiled in.
//   FIFO_DEPTH : capacity of the response buffer.
//   resp_entry_t : response-entry layout {data, addr, err} for the default
//                geometry (32-bit data, 12-bit byte address). The top packs
//                entries in the same field order for any geometry.
package inst_mem_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [11:0] addr;
    logic        err;
  } resp_entry_t;

endpackage

// File: rtl/inst_mem_fifo2.sv
// Two-entry in-order synchronous FIFO used as the fetch response buffer.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high flush
//   push, push_data : enqueue one entry (caller never pushes when full)
//   pop            : dequeue head (caller never pops when empty)
//   head_data      : current head entry (slot 0)
//   count          : number of valid entries, 0..2
// Storage is a two-slot shift structure: slot 0 is always the head, so the
// head needs no read mux.
module inst_mem_fifo2 #(
  parameter int W = 45
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;

  assign head_data = slot0;

  always_ff @(posedge clock) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new entry arrives: the new entry lands
          // directly behind whatever remains, count is unchanged.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_pipe.sv
// Parametrised instruction memory with a valid/ready fetch port, a one-cycle
// in-flight read register, a 2-entry response buffer and a program-load port.
// Optional feature macro: INSTMEM_ALIGN_CHECK_EN (misaligned fetch -> NOP+err).
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     : fetch request handshake, req_addr = byte address
//   resp_valid/resp_ready   : response handshake; resp_data/addr/err = head
//   prog_we/prog_addr/prog_data : word-addressed program write port
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and req_ready may depend
// combinationally on resp_ready so a pop frees a slot in the same cycle.
module inst_mem_pipe
  import inst_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter int    DATA_WIDTH = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH+1:0] resp_addr,
  output logic                  resp_err,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;
  localparam int EW    = DATA_WIDTH + AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  accept;
  logic                  pop;
  logic                  use_fifo;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [EW-1:0]         fifo_head;
  logic [2:0]            occ_next;

  logic                  infl_valid;
  logic [DATA_WIDTH-1:0] infl_data;
  logic [AW-1:0]         infl_addr;
  logic                  infl_err;

  assign idx = req_addr[AW-1:2];

`ifdef INSTMEM_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Program writes; a read is never accepted in the same cycle as a write.
  always_ff @(posedge clock) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // In-flight register: the array is read at the accepting edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      infl_valid <= 1'b0;
      infl_data  <= '0;
      infl_addr  <= '0;
      infl_err   <= 1'b0;
    end else begin
      infl_valid <= accept;
      if (accept) begin
        infl_addr <= req_addr;
        infl_err  <= misaligned;
        infl_data <= misaligned ? DATA_WIDTH'(NOP) : mem[idx];
      end
    end
  end

  // With an empty buffer the in-flight word is presented directly, giving
  // resp_valid the cycle after the accept; otherwise it queues behind.
  assign use_fifo   = (fifo_count != 2'd0);
  assign resp_valid = use_fifo || infl_valid;
  assign pop        = resp_valid && resp_ready;
  assign fifo_pop   = pop && use_fifo;
  assign fifo_push  = infl_valid && (use_fifo || !resp_ready);

  always_comb begin
    resp_data = infl_data;
    resp_addr = infl_addr;
    resp_err  = infl_err;
    if (use_fifo) {resp_data, resp_addr, resp_err} = fifo_head;
  end

  // Occupancy after this edge if nothing new is accepted.
  assign occ_next  = {1'b0, fifo_count} + {2'b00, infl_valid} - {2'b00, pop};
  assign req_ready = !reset && !prog_we && (occ_next < 3'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  inst_mem_fifo2 #(.W(EW)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({infl_data, infl_addr, infl_err}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_inst_mem_pipe.sv
module tb_inst_mem_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [11:0] resp_addr;
  logic        resp_err;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  inst_mem_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    n_checks++; if (resp_addr !== 12'h0) begin n_fail++; $display("FAIL reset_resp_addr: got %h expected 0", resp_addr); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    tick();
    reset = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    prog_we = 1'b1; prog_addr = 10'd1023; prog_data = 32'hCAFE_F00D;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic test_stream();
    resp_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      req_valid = (i < 16);
      req_addr  = 12'(i * 4);
      @(negedge clock);
      if (i < 16) begin
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, req_ready); end
      end
      if (i >= 1 && i <= 16) begin
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, resp_valid); end
        n_checks++; if (resp_data !== 32'h1000_0000 + 32'(i - 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, resp_data, 32'h1000_0000 + 32'(i - 1)); end
        n_checks++; if (resp_addr !== 12'((i - 1) * 4)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, resp_addr, 12'((i - 1) * 4)); end
      end else if (i == 17) begin
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", resp_valid); end
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_addr = 12'(accepts * 4);
      @(negedge clock);
      n_checks++; if (req_ready !== (c < 2)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, req_ready, (c < 2)); end
      if (req_ready) accepts++;
      tick();
    end
    n_checks++; if (accepts != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", accepts); end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0000 || resp_addr !== 12'h000) begin n_fail++; $display("FAIL bp_first: got v=%b d=%h a=%h expected v=1 d=10000000 a=000", resp_valid, resp_data, resp_addr); end
    tick();
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0001 || resp_addr !== 12'h004) begin n_fail++; $display("FAIL bp_second: got v=%b d=%h a=%h expected v=1 d=10000001 a=004", resp_valid, resp_data, resp_addr); end
    tick();
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", resp_valid); end
  endtask

  task automatic test_prog_priority();
    resp_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 10'd3; prog_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 12'd12;
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL prog_blocks_ready: got %b expected 0", req_ready); end
    tick();
    prog_we = 1'b0;
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL prog_after_ready: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF || resp_addr !== 12'd12) begin n_fail++; $display("FAIL write_then_read: got v=%b d=%h a=%h expected v=1 d=deadbeef a=00c", resp_valid, resp_data, resp_addr); end
    tick();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'd8;
    tick(); tick(); tick();
    req_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_buffered: got %b expected 1", resp_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flushed: got %b expected 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", req_ready); end
    tick();
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stays_empty: got %b expected 0", resp_valid); end
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b1; req_addr = 12'd8;
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0002) begin n_fail++; $display("FAIL rmid_refetch: got v=%b d=%h expected v=1 d=10000002", resp_valid, resp_data); end
    tick();
  endtask

  task automatic test_align();
    logic [31:0] exp_data;
    logic        exp_err;
`ifdef INSTMEM_ALIGN_CHECK_EN
    exp_data = 32'h0000_0013; exp_err = 1'b1;
`else
    exp_data = 32'h1000_0001; exp_err = 1'b0;
`endif
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'h006;
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (resp_err !== exp_err) begin n_fail++; $display("FAIL align_err: got %b expected %b", resp_err, exp_err); end
    n_checks++; if (resp_data !== exp_data) begin n_fail++; $display("FAIL align_data: got %h expected %h", resp_data, exp_data); end
    n_checks++; if (resp_addr !== 12'h006) begin n_fail++; $display("FAIL align_addr: got %h expected 006", resp_addr); end
    tick();
  endtask

  task automatic test_last_word();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'hFFC;
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE_F00D || resp_addr !== 12'hFFC) begin n_fail++; $display("FAIL last_word: got v=%b d=%h a=%h expected v=1 d=cafef00d a=ffc", resp_valid, resp_data, resp_addr); end
    tick();
  endtask

  initial begin
    test_reset();
    load_program();
    test_stream();
    test_backpressure();
    test_prog_priority();
    test_reset_mid();
    test_align();
    test_last_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
